bin2bcd_converter: RTL

Sequential binary-to-BCD converter for the score and line-count displays. It accepts an unsigned binary value on a start strobe and runs the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It then presents packed BCD digits with a one-cycle done pulse. Each output nibble drives one `BCD2SEVENSEGMENT` decoder, so this block is the producer end of the decoder's `bcd` input.

---
 rtl/tetris_pkg.sv | 15 +
 rtl/bcd_digit_adjust.sv | 12 +
 rtl/bin2bcd_converter.sv | 111 +++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris display path.
// The BCD converter and its digit-adjust cell import this package.
package tetris_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_t;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: one BCD digit gets +3 when it is 5 or more,
// so that the following left shift carries correctly into the next decade.
module bcd_digit_adjust
    import tetris_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i + BCD_ADJ_ADD) : digit_i;

endmodule

// File: rtl/bin2bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// feeding the score and line-count seven-segment decoders.
module bin2bcd_converter
    import tetris_pkg::*;
#(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BIN_WIDTH-1:0]   bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGITS-1:0]    bcd,
    output logic                   overflow
);

    localparam int                 BCD_W     = BCD_DIGIT_W * DIGITS;
    localparam int                 SCR_W     = BCD_DIGIT_W * (DIGITS + 1);
    localparam int                 CNT_W     = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(BIN_WIDTH);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [31:0]        OVF_LIMIT = 32'(10 ** DIGITS - 1);
    localparam logic [BCD_W-1:0]   ALL_NINES = {DIGITS{4'h9}};

    bcd_state_t             state_q, state_d;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d;
    logic [SCR_W-1:0]       scratch_q, scratch_d;
    logic [SCR_W-1:0]       scratch_adj;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_pend_q, ovf_pend_d;
    logic                   busy_q, done_q, overflow_q;
    logic [BCD_W-1:0]       bcd_q;
    logic                   unused_top_bit;

    // The extra scratch digit absorbs the carry of inputs above 10^DIGITS-1.
    for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (scratch_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign unused_top_bit = scratch_adj[SCR_W-1];

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d      = bin;
                    scratch_d  = '0;
                    cnt_d      = CNT_LOAD;
                    ovf_pend_d = ({{(32-BIN_WIDTH){1'b0}}, bin} > OVF_LIMIT);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, bin_d} = {scratch_adj[SCR_W-2:0], bin_q, 1'b0};
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            // Outputs are registered, so they trail the FSM by one cycle.
            busy_q     <= (state_q != IDLE);
            done_q     <= (state_q == FINISH);
            if (state_q == FINISH) begin
                bcd_q      <= ovf_pend_q ? ALL_NINES : scratch_q[BCD_W-1:0];
                overflow_q <= ovf_pend_q;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule
